// File: rtl/shift_pkg.sv
// Shared encodings for the bit-serial shifter: operation codes and FSM states.
package shift_pkg;

  localparam int WORD_DEF = 32;
  localparam int SHW_DEF  = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift1_step.sv
// One-bit shift/rotate stage; the sequencer applies it once per SHIFT cycle.
module shift1_step
  import shift_pkg::*;
#(
  parameter int WORD = WORD_DEF
) (
  input  shift_op_e         op_i,
  input  logic [WORD-1:0]   operand_i,
  output logic [WORD-1:0]   operand_o
);

  always_comb begin
    operand_o = operand_i;
    case (op_i)
      OP_SLL:  operand_o = {operand_i[WORD-2:0], 1'b0};
      OP_SRL:  operand_o = {1'b0, operand_i[WORD-1:1]};
      OP_SRA:  operand_o = {operand_i[WORD-1], operand_i[WORD-1:1]};
      OP_ROL:  operand_o = {operand_i[WORD-2:0], operand_i[WORD-1]};
      default: operand_o = operand_i;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Bit-serial shifter: one 1-bit step per cycle, done_o in cycle T+shamt+1.
// Handshake: start_i is taken on any edge where state is IDLE or DONE; it is
// ignored in SHIFT. done_o pulses one cycle with result_o valid, busy_o is high in SHIFT.
module shift_seq
  import shift_pkg::*;
#(
  parameter int WORD = WORD_DEF,
  parameter int SHW  = SHW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [SHW-1:0]  shamt_i,
  input  logic [WORD-1:0] data_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [WORD-1:0] result_o
);

  shift_state_e    state_q, state_d;
  shift_op_e       op_q, op_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [WORD-1:0] result_q, result_d;
  logic [WORD-1:0] stepped;
  logic            accept;

  shift1_step #(.WORD(WORD)) u_step (
    .op_i      (op_q),
    .operand_i (result_q),
    .operand_o (stepped)
  );

  assign accept = start_i && (state_q != ST_SHIFT);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (accept) begin
      op_d     = shift_op_e'(op_i);
      cnt_d    = shamt_i;
      result_d = data_i;
      state_d  = (shamt_i == '0) ? ST_DONE : ST_SHIFT;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          result_d = stepped;
          cnt_d    = cnt_q - SHW'(1);
          // Final step happens in the same cycle that cnt reads 1.
          if (cnt_q == SHW'(1)) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SLL;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == ST_SHIFT);
  assign done_o   = (state_q == ST_DONE);
  assign result_o = result_q;

endmodule
